// File: rtl/spi_memory_if.sv
// SPI pin bundle between the external master and the spi_memory slave.
// miso_en reports whether the slave is currently driving miso_pin.
interface spi_memory_if;
  logic sclk_pin;
  logic cs_pin;
  logic mosi_pin;
  logic miso_en;

  modport slave (
    input  sclk_pin,
    input  cs_pin,
    input  mosi_pin,
    output miso_en
  );

  modport master (
    output sclk_pin,
    output cs_pin,
    output mosi_pin,
    input  miso_en
  );
endinterface

// File: rtl/spi_memory.sv
// SPI mode-0 slave in front of a 2^ADDR_WIDTH x DATA_WIDTH register file.
// The pins are synchronized and debounced into clk, and an FSM decodes {addr, R/W} then moves one data word.
module spi_memory #(
  parameter int ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH    = 8,
  parameter int DEBOUNCE_WAIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  spi_memory_if.slave      spi,
  output logic             miso_pin,
  output logic [3:0]       leds
);

  localparam int CMD_BITS = ADDR_WIDTH + 1;
  localparam int SH_W     = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
  localparam int CNT_W    = $clog2(SH_W);
  localparam int DB_W     = (DEBOUNCE_WAIT > 1) ? $clog2(DEBOUNCE_WAIT) : 1;
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_WAIT - 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  // Pin order is {mosi, cs, sclk}; cs idles high.
  localparam logic [2:0] COND_RST = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_DECODE   = 3'd2,
    ST_READ     = 3'd3,
    ST_WRITE    = 3'd4,
    ST_STORE    = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  logic [2:0]      pins_s;
  logic [2:0]      sync1_q, sync2_q, cond_q, cond_d;
  logic [2:0]      upd_s;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [1:0]      rise_q, rise_d, fall_q, fall_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  out_sr_q, out_sr_d;
  logic                   miso_bit_q, miso_bit_d;
  logic                   miso_en_q, miso_en_d;
  logic [3:0]             leds_q, leds_d;
  logic                   mem_we_s;
  logic [DATA_WIDTH-1:0]  rd_data_s;
  logic [DATA_WIDTH-1:0]  mem_q [2**ADDR_WIDTH];

  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, mosi_s;

  assign pins_s      = {spi.mosi_pin, spi.cs_pin, spi.sclk_pin};
  assign sclk_rise_s = rise_q[0];
  assign sclk_fall_s = fall_q[0];
  assign cs_rise_s   = rise_q[1];
  assign cs_fall_s   = fall_q[1];
  assign mosi_s      = cond_q[2];
  assign rd_data_s   = mem_q[shift_q[ADDR_WIDTH:1]];

  // Debounce: accept a new synchronized level after DEBOUNCE_WAIT consecutive differing clks.
  always_comb begin
    cond_d = cond_q;
    upd_s  = 3'b000;
    for (int p = 0; p < 3; p++) begin
      db_cnt_d[p] = '0;
      if (sync2_q[p] != cond_q[p]) begin
        if (db_cnt_q[p] == DB_LAST) begin
          upd_s[p]  = 1'b1;
          cond_d[p] = sync2_q[p];
        end else begin
          db_cnt_d[p] = db_cnt_q[p] + DB_W'(1);
        end
      end else begin
        db_cnt_d[p] = '0;
      end
    end
    rise_d = upd_s[1:0] & sync2_q[1:0];
    fall_d = upd_s[1:0] & ~sync2_q[1:0];
  end

  // Synchronizer, debounce and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= COND_RST;
      sync2_q <= COND_RST;
      cond_q  <= COND_RST;
      rise_q  <= 2'b00;
      fall_q  <= 2'b00;
      for (int p = 0; p < 3; p++) begin
        db_cnt_q[p] <= '0;
      end
    end else begin
      sync1_q <= pins_s;
      sync2_q <= sync1_q;
      cond_q  <= cond_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int p = 0; p < 3; p++) begin
        db_cnt_q[p] <= db_cnt_d[p];
      end
    end
  end

  // Transfer FSM: next state, shifters, MISO and LED updates.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    out_sr_d   = out_sr_q;
    miso_bit_d = miso_bit_q;
    miso_en_d  = miso_en_q;
    leds_d     = leds_q;
    mem_we_s   = 1'b0;
    if ((state_q != ST_IDLE) && cs_rise_s) begin
      // Deselect aborts whatever is in flight; STORE is skipped, so nothing is written.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = '0;
          miso_en_d = 1'b0;
          if (cs_fall_s) begin
            state_d = ST_GET_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GET_ADDR: begin
          if (sclk_rise_s) begin
            shift_d = {shift_q[SH_W-2:0], mosi_s};
            if (bit_cnt_q == CMD_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_DECODE;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_GET_ADDR;
          end
        end
        ST_DECODE: begin
          addr_d = shift_q[ADDR_WIDTH:1];
          if (shift_q[0]) begin
            out_sr_d   = rd_data_s;
            miso_bit_d = rd_data_s[DATA_WIDTH-1];
            miso_en_d  = 1'b1;
            leds_d     = rd_data_s[3:0];
            state_d    = ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_READ: begin
          if (sclk_fall_s) begin
            miso_bit_d = out_sr_q[DATA_WIDTH-1];
            out_sr_d   = {out_sr_q[DATA_WIDTH-2:0], 1'b0};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_READ;
          end
        end
        ST_WRITE: begin
          if (sclk_rise_s) begin
            shift_d = {shift_q[SH_W-2:0], mosi_s};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_STORE;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_STORE: begin
          mem_we_s = 1'b1;
          leds_d   = shift_q[3:0];
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          miso_en_d = 1'b0;
        end
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      out_sr_q   <= '0;
      miso_bit_q <= 1'b0;
      miso_en_q  <= 1'b0;
      leds_q     <= 4'h0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      out_sr_q   <= out_sr_d;
      miso_bit_q <= miso_bit_d;
      miso_en_q  <= miso_en_d;
      leds_q     <= leds_d;
    end
  end

  // Register file write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_q[addr_q] <= shift_q[DATA_WIDTH-1:0];
    end
  end

  assign miso_pin    = miso_en_q ? miso_bit_q : 1'bz;
  assign spi.miso_en = miso_en_q;
  assign leds        = leds_q;

endmodule

// File: tb/tb_spi_memory.sv
// Directed bench for spi_memory: table of whole transfers plus abort, glitch and reset-mid-read sequences.
module tb_spi_memory;

  localparam int PH = 50;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic [3:0] exp_leds;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  wire        miso_w;
  logic [3:0] leds;
  int         n_tests = 0;
  int         n_fail  = 0;

  spi_memory_if spi_if ();

  spi_memory dut (
    .clk      (clk),
    .reset    (reset),
    .spi      (spi_if),
    .miso_pin (miso_w),
    .leds     (leds)
  );

  always #5 clk = ~clk;

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    for (int i = 7; i >= 0; i--) begin
      spi_if.sclk_pin = 1'b0;
      spi_if.mosi_pin = cmd[i];
      wclk(PH);
      spi_if.sclk_pin = 1'b1;
      wclk(PH);
    end
  endtask

  // Full framed transfer: command byte, nd data cycles, then deselect.
  task automatic xfer(input logic [7:0] cmd, input logic [7:0] wd, input int nd,
                      output logic [7:0] rb, output logic [7:0] eb, output logic [1:0] pre);
    rb = 8'h00;
    eb = 8'h00;
    spi_if.cs_pin = 1'b0;
    wclk(PH);
    send_cmd(cmd);
    pre = {spi_if.miso_en, miso_w};
    for (int i = 0; i < nd; i++) begin
      spi_if.sclk_pin = 1'b0;
      spi_if.mosi_pin = wd[7-i];
      wclk(PH);
      rb[7-i] = miso_w;
      eb[7-i] = spi_if.miso_en;
      spi_if.sclk_pin = 1'b1;
      wclk(PH);
    end
    spi_if.sclk_pin = 1'b0;
    spi_if.mosi_pin = 1'b0;
    wclk(PH);
    spi_if.cs_pin = 1'b1;
    wclk(PH);
  endtask

  vec_t       vecs [8];
  logic [7:0] rb, eb;
  logic [1:0] pre;

  initial begin
    vecs[0] = '{cmd: 8'h00, wdata: 8'hFF, exp_rd: 8'h00, exp_leds: 4'hF};
    vecs[1] = '{cmd: 8'h01, wdata: 8'h00, exp_rd: 8'hFF, exp_leds: 4'hF};
    vecs[2] = '{cmd: 8'h6A, wdata: 8'hB1, exp_rd: 8'h00, exp_leds: 4'h1};
    vecs[3] = '{cmd: 8'h6B, wdata: 8'h00, exp_rd: 8'hB1, exp_leds: 4'h1};
    vecs[4] = '{cmd: 8'h0A, wdata: 8'h5A, exp_rd: 8'h00, exp_leds: 4'hA};
    vecs[5] = '{cmd: 8'hFE, wdata: 8'h3C, exp_rd: 8'h00, exp_leds: 4'hC};
    vecs[6] = '{cmd: 8'hFF, wdata: 8'h00, exp_rd: 8'h3C, exp_leds: 4'hC};
    vecs[7] = '{cmd: 8'h01, wdata: 8'h00, exp_rd: 8'hFF, exp_leds: 4'hF};

    reset = 1'b1;
    spi_if.cs_pin   = 1'b1;
    spi_if.sclk_pin = 1'b0;
    spi_if.mosi_pin = 1'b0;
    wclk(5);
    check("reset_leds", {28'd0, leds}, 32'h0);
    check("reset_miso_en", {31'd0, spi_if.miso_en}, 32'h0);
    reset = 1'b0;
    wclk(PH);

    for (int v = 0; v < 8; v++) begin
      xfer(vecs[v].cmd, vecs[v].wdata, 8, rb, eb, pre);
      if (vecs[v].cmd[0]) begin
        check($sformatf("v%0d_pre_bit7", v), {30'd0, pre}, {30'd0, 1'b1, vecs[v].exp_rd[7]});
        check($sformatf("v%0d_rd_byte", v), {24'd0, rb}, {24'd0, vecs[v].exp_rd});
        check($sformatf("v%0d_miso_en", v), {24'd0, eb}, 32'hFF);
      end else begin
        check($sformatf("v%0d_pre_en", v), {31'd0, pre[1]}, 32'h0);
        check($sformatf("v%0d_miso_en", v), {24'd0, eb}, 32'h0);
      end
      check($sformatf("v%0d_leds", v), {28'd0, leds}, {28'd0, vecs[v].exp_leds});
      check($sformatf("v%0d_idle_en", v), {31'd0, spi_if.miso_en}, 32'h0);
    end

    // Abort a write to addr 5 after 12 bits; mem[5] must keep 0x5A.
    xfer(8'h0A, 8'h00, 4, rb, eb, pre);
    check("abort_leds", {28'd0, leds}, 32'hF);
    check("abort_en", {31'd0, spi_if.miso_en}, 32'h0);
    xfer(8'h0B, 8'h00, 8, rb, eb, pre);
    check("abort_rd", {24'd0, rb}, 32'h5A);
    check("abort_rd_leds", {28'd0, leds}, 32'hA);

    // Single-clk sclk glitches while selected must not advance the bit counter.
    spi_if.cs_pin = 1'b0;
    wclk(PH);
    for (int g = 0; g < 6; g++) begin
      spi_if.sclk_pin = 1'b1;
      wclk(1);
      spi_if.sclk_pin = 1'b0;
      wclk(10);
    end
    check("glitch_en", {31'd0, spi_if.miso_en}, 32'h0);
    xfer(8'h6B, 8'h00, 8, rb, eb, pre);
    check("glitch_rd", {24'd0, rb}, 32'hB1);
    check("glitch_leds", {28'd0, leds}, 32'h1);

    // Reset in the middle of a read data phase.
    spi_if.cs_pin = 1'b0;
    wclk(PH);
    send_cmd(8'h6B);
    for (int i = 0; i < 3; i++) begin
      spi_if.sclk_pin = 1'b0;
      wclk(PH);
      spi_if.sclk_pin = 1'b1;
      wclk(PH);
    end
    check("pre_reset_en", {31'd0, spi_if.miso_en}, 32'h1);
    reset = 1'b1;
    wclk(3);
    check("rst_mid_en", {31'd0, spi_if.miso_en}, 32'h0);
    check("rst_mid_leds", {28'd0, leds}, 32'h0);
    spi_if.cs_pin   = 1'b1;
    spi_if.sclk_pin = 1'b0;
    wclk(5);
    reset = 1'b0;
    wclk(PH);
    check("rst_after_en", {31'd0, spi_if.miso_en}, 32'h0);
    xfer(8'h6B, 8'h00, 8, rb, eb, pre);
    check("rst_mem_kept", {24'd0, rb}, 32'hB1);
    check("rst_rd_leds", {28'd0, leds}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
